// File: rtl/pc_stack_sequencer_pkg.sv
// Shared definitions for the PC return-stack sequencer and its counter.
package pc_stack_sequencer_pkg;

  typedef logic [7:0]  BYTE;
  typedef logic        CONTROL;
  typedef logic [15:0] PROGRAM_COUNTER;

  typedef enum logic [1:0] {
    PUSH = 2'b00,
    POP  = 2'b01,
    PEEK = 2'b10,
    DROP = 2'b11
  } STACK_OP;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_HI,
    S_PUSH_LO,
    S_RD_LO,
    S_RD_HI,
    S_CAP_HI,
    S_LOAD,
    S_DONE,
    S_ERR
  } SEQ_STATE;

  // Byte address of the upper byte of stack entry idx.
  function automatic PROGRAM_COUNTER entry_addr(input PROGRAM_COUNTER base,
                                                input PROGRAM_COUNTER idx);
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/pc_stack_sequencer_stack_counter.sv
// Entry counter for the return stack: up/down count, full/empty flags and
// the byte addresses of the current top entry and the next free entry.
module stack_counter
  import pc_stack_sequencer_pkg::*;
#(
  parameter PROGRAM_COUNTER STACK_BASE  = 16'hFF00,
  parameter int unsigned    STACK_DEPTH = 128
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inc,
  input  logic                               dec,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
  output logic                               empty,
  output logic                               full,
  output PROGRAM_COUNTER                     top_addr,
  output PROGRAM_COUNTER                     next_addr
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  // Entry count register; inc and dec are never requested together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end

  // Flags and entry addresses derived from the count.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(STACK_DEPTH));
    next_addr = entry_addr(STACK_BASE, PROGRAM_COUNTER'(count));
    top_addr  = next_addr - 16'd2;
  end

endmodule

// File: rtl/pc_stack_sequencer.sv
// Byte-serial PC save/restore sequencer between the datapath and a return
// stack in data memory. Drives the cache unit's loader_select, memory
// address/strobes and the PC load strobe.
module pc_stack_sequencer
  import pc_stack_sequencer_pkg::*;
#(
  parameter PROGRAM_COUNTER STACK_BASE  = 16'hFF00,
  parameter int unsigned    STACK_DEPTH = 128
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [1:0]                       cmd_op,
  output logic                             cmd_ready,
  output CONTROL                           loader_select,
  output PROGRAM_COUNTER                   mem_addr,
  output logic                             mem_write_en,
  output logic                             mem_read_en,
  output logic                             pc_load_en,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             empty,
  output logic                             full
);

  SEQ_STATE       state, state_next;
  STACK_OP        op_q;
  STACK_OP        op_in;
  logic           accept;
  logic           err_cond;
  logic           cnt_inc, cnt_dec;
  PROGRAM_COUNTER top_addr, next_addr;

  stack_counter #(
    .STACK_BASE  (STACK_BASE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .inc       (cnt_inc),
    .dec       (cnt_dec),
    .count     (stack_count),
    .empty     (empty),
    .full      (full),
    .top_addr  (top_addr),
    .next_addr (next_addr)
  );

  // Acceptance, error detection and counter steering.
  always_comb begin
    op_in    = STACK_OP'(cmd_op);
    accept   = (state == S_IDLE) && cmd_valid;
    err_cond = (op_in == PUSH) ? full : empty;
    cnt_inc  = (state == S_PUSH_LO);
    // DROP retires the entry on the accepting edge; POP retires it on LOAD.
    cnt_dec  = ((state == S_LOAD) && (op_q == POP)) ||
               (accept && (op_in == DROP) && !err_cond);
  end

  // State register and command latch; the op is captured only on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= PUSH;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q <= op_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (err_cond) begin
            state_next = S_ERR;
          end else begin
            case (op_in)
              PUSH:      state_next = S_PUSH_HI;
              POP, PEEK: state_next = S_RD_LO;
              default:   state_next = S_DONE;
            endcase
          end
        end
      end
      S_PUSH_HI: state_next = S_PUSH_LO;
      S_PUSH_LO: state_next = S_DONE;
      S_RD_LO:   state_next = S_RD_HI;
      S_RD_HI:   state_next = S_CAP_HI;
      S_CAP_HI:  state_next = S_LOAD;
      S_LOAD:    state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      S_ERR:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    cmd_ready     = 1'b0;
    loader_select = 1'b0;
    mem_addr      = STACK_BASE;
    mem_write_en  = 1'b0;
    mem_read_en   = 1'b0;
    pc_load_en    = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state)
      S_IDLE:    cmd_ready = 1'b1;
      S_PUSH_HI: begin
        mem_addr      = next_addr;
        mem_write_en  = 1'b1;
        loader_select = 1'b1;
      end
      S_PUSH_LO: begin
        mem_addr     = next_addr + 16'd1;
        mem_write_en = 1'b1;
      end
      S_RD_LO: begin
        mem_addr    = top_addr + 16'd1;
        mem_read_en = 1'b1;
      end
      S_RD_HI: begin
        mem_addr    = top_addr;
        mem_read_en = 1'b1;
      end
      S_CAP_HI:  loader_select = 1'b1;
      S_LOAD:    pc_load_en = 1'b1;
      S_DONE:    done = 1'b1;
      S_ERR: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer with a behavioural memory and
// cache-unit model (save mux, upper/lower load registers, PC register).
module tb_pc_stack_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic        cmd_ready, loader_select, mem_write_en, mem_read_en;
  logic        pc_load_en, done, error, empty, full;
  logic [15:0] mem_addr;
  logic [7:0]  stack_count;

  pc_stack_sequencer #(.STACK_BASE(16'hFF00), .STACK_DEPTH(128)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_ready     (cmd_ready),
    .loader_select (loader_select),
    .mem_addr      (mem_addr),
    .mem_write_en  (mem_write_en),
    .mem_read_en   (mem_read_en),
    .pc_load_en    (pc_load_en),
    .done          (done),
    .error         (error),
    .stack_count   (stack_count),
    .empty         (empty),
    .full          (full)
  );

  always #5 clock = ~clock;

  // Environment model
  logic [7:0]  mem [0:65535];
  logic [7:0]  mem_out = 8'h00;
  logic        rd_q = 1'b0;
  logic [7:0]  upper = 8'h00, lower = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic        pc_wr = 1'b0;
  logic [15:0] pc_wr_val = 16'h0000;

  always @(posedge clock) begin
    if (mem_write_en) mem[mem_addr] <= loader_select ? pc[15:8] : pc[7:0];
    rd_q <= mem_read_en;
    if (mem_read_en) mem_out <= mem[mem_addr];
    if (rd_q) begin
      if (loader_select) upper <= mem_out;
      else               lower <= mem_out;
    end
    if (pc_load_en)  pc <= {upper, lower};
    else if (pc_wr)  pc <= pc_wr_val;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    @(negedge clock);
    pc_wr = 1'b1;
    pc_wr_val = v;
    @(negedge clock);
    pc_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [15:0] wr_addr [4];
  logic        wr_sel  [4];
  logic [15:0] rd_addr [4];

  // Issue one command and follow it to done; cycle 1 is the cycle after acceptance.
  task automatic run_cmd(input logic [1:0] op, output int lat, output logic err,
                         output int nwr, output int nrd, output int nld);
    int both;
    nwr = 0; nrd = 0; nld = 0; both = 0; err = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    check("ready before accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    for (lat = 1; lat <= 20; lat++) begin
      if (mem_write_en && mem_read_en) both++;
      if (mem_write_en) begin
        if (nwr < 4) begin wr_addr[nwr] = mem_addr; wr_sel[nwr] = loader_select; end
        nwr++;
      end
      if (mem_read_en) begin
        if (nrd < 4) rd_addr[nrd] = mem_addr;
        nrd++;
      end
      if (pc_load_en) nld++;
      if (done) break;
      @(posedge clock);
      #1;
    end
    if (lat > 20) check("done timeout", 32'd0, 32'd1);
    err = error;
    check("wr and rd together", both, 0);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] pc_in;
    logic        exp_err;
    logic [15:0] exp_pc;
    int          exp_count;
    int          exp_lat;
    bit          lat_max;   // 1: latency is an upper bound, 0: exact
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, nrd, nld;
    logic err;
    logic [1:0] op;

    //            op     pc_in     err   exp_pc    cnt lat max
    vecs[0]  = '{2'b00, 16'h1234, 1'b0, 16'h1234, 1,  3,  1'b0};
    vecs[1]  = '{2'b00, 16'h5678, 1'b0, 16'h5678, 2,  3,  1'b0};
    vecs[2]  = '{2'b10, 16'h0000, 1'b0, 16'h5678, 2,  5,  1'b0};
    vecs[3]  = '{2'b01, 16'h0000, 1'b0, 16'h5678, 1,  5,  1'b0};
    vecs[4]  = '{2'b01, 16'h0000, 1'b0, 16'h1234, 0,  5,  1'b0};
    vecs[5]  = '{2'b01, 16'h0000, 1'b1, 16'hDEAD, 0,  2,  1'b1};
    vecs[6]  = '{2'b10, 16'h0000, 1'b1, 16'hDEAD, 0,  2,  1'b1};
    vecs[7]  = '{2'b11, 16'h0000, 1'b1, 16'hDEAD, 0,  2,  1'b1};
    vecs[8]  = '{2'b00, 16'hABCD, 1'b0, 16'hABCD, 1,  3,  1'b0};
    vecs[9]  = '{2'b11, 16'h0000, 1'b0, 16'hDEAD, 0,  2,  1'b1};
    vecs[10] = '{2'b00, 16'h00FF, 1'b0, 16'h00FF, 1,  3,  1'b0};
    vecs[11] = '{2'b10, 16'h0000, 1'b0, 16'h00FF, 1,  5,  1'b0};
    vecs[12] = '{2'b00, 16'h8001, 1'b0, 16'h8001, 2,  3,  1'b0};
    vecs[13] = '{2'b01, 16'h0000, 1'b0, 16'h8001, 1,  5,  1'b0};
    vecs[14] = '{2'b01, 16'h0000, 1'b0, 16'h00FF, 0,  5,  1'b0};

    // Reset values, sampled while reset is held
    #3;
    check("reset ready",   {31'd0, cmd_ready}, 32'd1);
    check("reset sel",     {31'd0, loader_select}, 32'd0);
    check("reset addr",    {16'd0, mem_addr}, 32'h0000FF00);
    check("reset strobes", {28'd0, mem_write_en, mem_read_en, pc_load_en, done}, 32'd0);
    check("reset error",   {31'd0, error}, 32'd0);
    check("reset count",   {24'd0, stack_count}, 32'd0);
    check("reset empty",   {30'd0, empty, full}, 32'd2);
    do_reset();

    // Table-driven command sequence
    for (int i = 0; i < 15; i++) begin
      op = vecs[i].op;
      set_pc((op == 2'b00) ? vecs[i].pc_in : 16'hDEAD);
      run_cmd(op, lat, err, nwr, nrd, nld);
      if (vecs[i].lat_max) check($sformatf("v%0d latency<=%0d", i, vecs[i].exp_lat), {31'd0, lat <= vecs[i].exp_lat}, 32'd1);
      else                 check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d count", i), {24'd0, stack_count}, vecs[i].exp_count);
      check($sformatf("v%0d empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_count == 0});
      check($sformatf("v%0d pc", i), {16'd0, pc}, {16'd0, vecs[i].exp_pc});
      check($sformatf("v%0d writes", i), nwr, (!vecs[i].exp_err && op == 2'b00) ? 2 : 0);
      check($sformatf("v%0d reads", i), nrd, (!vecs[i].exp_err && (op == 2'b01 || op == 2'b10)) ? 2 : 0);
      check($sformatf("v%0d pc loads", i), nld, (!vecs[i].exp_err && (op == 2'b01 || op == 2'b10)) ? 1 : 0);
      if (i == 0) begin
        check("push wr0 addr", {16'd0, wr_addr[0]}, 32'h0000FF00);
        check("push wr0 sel",  {31'd0, wr_sel[0]}, 32'd1);
        check("push wr1 addr", {16'd0, wr_addr[1]}, 32'h0000FF01);
        check("push wr1 sel",  {31'd0, wr_sel[1]}, 32'd0);
        check("mem FF00", {24'd0, mem[16'hFF00]}, 32'h12);
        check("mem FF01", {24'd0, mem[16'hFF01]}, 32'h34);
      end
      if (i == 1) begin
        check("mem FF02", {24'd0, mem[16'hFF02]}, 32'h56);
        check("mem FF03", {24'd0, mem[16'hFF03]}, 32'h78);
      end
      if (i == 2) begin
        check("peek rd0 addr", {16'd0, rd_addr[0]}, 32'h0000FF03);
        check("peek rd1 addr", {16'd0, rd_addr[1]}, 32'h0000FF02);
      end
    end

    // Fill to capacity: PUSH at DEPTH-1 succeeds and sets full, next PUSH errors
    do_reset();
    begin
      int errs = 0;
      for (int i = 0; i < 127; i++) begin
        set_pc(16'(i));
        run_cmd(2'b00, lat, err, nwr, nrd, nld);
        if (err) errs++;
      end
      check("fill errors", errs, 0);
    end
    check("count at 127", {24'd0, stack_count}, 32'd127);
    check("not full at 127", {31'd0, full}, 32'd0);
    set_pc(16'h0BAD);
    run_cmd(2'b00, lat, err, nwr, nrd, nld);
    check("last push error", {31'd0, err}, 32'd0);
    check("count at 128", {24'd0, stack_count}, 32'd128);
    check("full at 128", {31'd0, full}, 32'd1);
    check("mem last hi", {24'd0, mem[16'hFFFE]}, 32'h0B);
    check("mem last lo", {24'd0, mem[16'hFFFF]}, 32'hAD);
    set_pc(16'hCAFE);
    run_cmd(2'b00, lat, err, nwr, nrd, nld);
    check("full push error", {31'd0, err}, 32'd1);
    check("full push writes", nwr, 0);
    check("full push latency<=2", {31'd0, lat <= 2}, 32'd1);
    check("count after full push", {24'd0, stack_count}, 32'd128);
    set_pc(16'hDEAD);
    run_cmd(2'b01, lat, err, nwr, nrd, nld);
    check("pop from full pc", {16'd0, pc}, 32'h00000BAD);
    check("pop from full count", {24'd0, stack_count}, 32'd127);
    check("pop from full flag", {31'd0, full}, 32'd0);

    // Reset asserted during RD_HI of a POP
    do_reset();
    set_pc(16'h1234);
    run_cmd(2'b00, lat, err, nwr, nrd, nld);
    set_pc(16'hDEAD);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    check("in RD_HI read", {31'd0, mem_read_en}, 32'd1);
    check("in RD_HI addr", {16'd0, mem_addr}, 32'h0000FF00);
    reset = 1'b1;
    #1;
    check("abort strobes", {28'd0, mem_write_en, mem_read_en, pc_load_en, done}, 32'd0);
    check("abort sel/err", {30'd0, loader_select, error}, 32'd0);
    check("abort addr", {16'd0, mem_addr}, 32'h0000FF00);
    check("abort count", {24'd0, stack_count}, 32'd0);
    check("abort ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    check("abort pc kept", {16'd0, pc}, 32'h0000DEAD);
    set_pc(16'h4321);
    run_cmd(2'b00, lat, err, nwr, nrd, nld);
    check("post-abort push error", {31'd0, err}, 32'd0);
    check("post-abort count", {24'd0, stack_count}, 32'd1);
    check("post-abort mem FF00", {24'd0, mem[16'hFF00]}, 32'h43);
    check("post-abort mem FF01", {24'd0, mem[16'hFF01]}, 32'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
